// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its write-side arbiter.
package fifo_pkg;

    localparam int DATA_SIZE = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2 with a minimum of 1 so that index fields are never zero width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// Round-robin rotate-and-find-first: the first set request strictly after last_grant, wrapping.
module rr_priority_picker
    import fifo_pkg::*;
#(
    parameter  int num_req  = 4,
    localparam int id_width = clog2(num_req)
) (
    input  logic [num_req-1:0]  req,
    input  logic [id_width-1:0] last_grant,
    output logic                found,
    output logic [id_width-1:0] index
);

    // Walk offsets from farthest to nearest so the nearest set request after last_grant wins.
    always_comb begin
        int candidate;
        candidate = 0;
        found     = 1'b0;
        index     = '0;
        for (int offset = num_req; offset >= 1; offset--) begin
            candidate = int'(last_grant) + offset;
            if (candidate >= num_req) begin
                candidate = candidate - num_req;
            end
            if (req[candidate[id_width-1:0]]) begin
                found = 1'b1;
                index = candidate[id_width-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between several write-domain producers.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter  int num_req   = 4,
    parameter  int data_size = DATA_SIZE,
    parameter  int burst_max = 4,
    localparam int id_width  = clog2(num_req),
    localparam int cnt_width = clog2(burst_max + 1)
) (
    input  logic                           write_clk,
    input  logic                           write_rst,
    input  logic [num_req-1:0]             req_valid,
    input  logic [num_req*data_size-1:0]   req_data,
    output logic [num_req-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           write_en,
    output logic [data_size-1:0]           write_data,
    output logic                           grant_valid,
    output logic [id_width-1:0]            grant_id
);

    arb_state_t            state;
    arb_state_t            state_next;
    logic                  grant_valid_next;
    logic [id_width-1:0]   grant_id_next;
    logic [cnt_width-1:0]  burst_cnt;
    logic [cnt_width-1:0]  burst_cnt_next;
    logic [id_width-1:0]   last_grant;
    logic [id_width-1:0]   last_grant_next;
    logic                  pick_found;
    logic [id_width-1:0]   pick_index;
    logic                  accept;

    rr_priority_picker #(
        .num_req (num_req)
    ) picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .found      (pick_found),
        .index      (pick_index)
    );

    // State register; reset leaves last_grant at the top index so requester 0 is served first.
    always_ff @(posedge write_clk) begin
        if (write_rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            burst_cnt   <= '0;
            last_grant  <= id_width'(num_req - 1);
        end else begin
            state       <= state_next;
            grant_valid <= grant_valid_next;
            grant_id    <= grant_id_next;
            burst_cnt   <= burst_cnt_next;
            last_grant  <= last_grant_next;
        end
    end

    // Next-state and zero-latency write path; no handshake is offered while reset is asserted.
    always_comb begin
        state_next       = state;
        grant_valid_next = grant_valid;
        grant_id_next    = grant_id;
        burst_cnt_next   = burst_cnt;
        last_grant_next  = last_grant;
        req_ready        = '0;
        write_en         = 1'b0;
        write_data       = '0;
        accept           = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_id_next    = pick_index;
                    grant_valid_next = 1'b1;
                    burst_cnt_next   = '0;
                    state_next       = GRANT;
                end
            end
            GRANT: begin
                if (!fifo_full && !write_rst) begin
                    req_ready[grant_id] = 1'b1;
                end
                accept   = req_valid[grant_id] && req_ready[grant_id];
                write_en = accept;
                if (accept) begin
                    write_data     = req_data[int'(grant_id)*data_size +: data_size];
                    burst_cnt_next = burst_cnt + cnt_width'(1);
                end
                if ((accept && (burst_cnt == cnt_width'(burst_max - 1))) ||
                    (!req_valid[grant_id] && !fifo_full)) begin
                    last_grant_next  = grant_id;
                    grant_valid_next = 1'b0;
                    grant_id_next    = '0;
                    burst_cnt_next   = '0;
                    state_next       = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with producer models, a write scoreboard and a FIFO model.
module tb_fifo_write_arbiter;
    import fifo_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int BURST   = 4;
    localparam int IDW     = 2;
    localparam int DEPTH   = 8;

    logic                    write_clk;
    logic                    write_rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*DW-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    fifo_full;
    logic                    write_en;
    logic [DW-1:0]           write_data;
    logic                    grant_valid;
    logic [IDW-1:0]          grant_id;

    fifo_write_arbiter #(
        .num_req   (NUM_REQ),
        .data_size (DW),
        .burst_max (BURST)
    ) dut (
        .write_clk   (write_clk),
        .write_rst   (write_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .write_en    (write_en),
        .write_data  (write_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Free-running write clock, period 10.
    initial begin
        write_clk = 1'b0;
        forever #5 write_clk = ~write_clk;
    end

    typedef struct {
        int         id;
        logic [7:0] data;
    } sb_entry_t;

    sb_entry_t  sb_q[$];
    logic [7:0] prod_mem [NUM_REQ][16];
    int         prod_head [NUM_REQ];
    int         prod_len [NUM_REQ];
    logic [7:0] fifo_q[$];
    bit         use_fifo_model;
    bit         manual_full;
    int         next_rd_idx [NUM_REQ];
    int         rd_count;
    int         cyc;
    int         grant_log[$];
    int         burst_log[$];
    int         burst_words;
    bit         prev_gv;
    logic       s_we, s_gv, s_full, s_rst;
    logic [7:0] s_wd;
    logic [IDW-1:0] s_gid;
    logic [NUM_REQ-1:0] s_ready, s_valid;
    int         total_checks;
    int         passed_checks;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_REQ; i++) begin
            prod_head[i]   = 0;
            prod_len[i]    = 0;
            next_rd_idx[i] = 0;
        end
        sb_q.delete();
        fifo_q.delete();
        grant_log.delete();
        burst_log.delete();
    endtask

    task automatic load_word(input int id, input logic [7:0] data);
        sb_entry_t e;
        prod_mem[id][prod_len[id]] = data;
        prod_len[id]++;
        e.id   = id;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (prod_head[i] < prod_len[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = prod_mem[i][prod_head[i]];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
        fifo_full = use_fifo_model ? (fifo_q.size() >= DEPTH) : manual_full;
    endtask

    task automatic sample_and_score();
        int hit;
        s_we    = write_en;
        s_wd    = write_data;
        s_gv    = grant_valid;
        s_gid   = grant_id;
        s_ready = req_ready;
        s_valid = req_valid;
        s_full  = fifo_full;
        s_rst   = write_rst;
        if (s_rst) begin
            prev_gv = 1'b0;
        end else begin
            check_output("we_while_full", s_we & s_full, 0);
            check_output("ready_onehot0", $onehot0(s_ready), 1);
            check_output("we_is_handshake", s_we, |(s_valid & s_ready));
            if (!s_gv) check_output("gid_idle_zero", s_gid, 0);
            if (s_we) begin
                check_output("ready_is_grantee", s_ready, 4'b0001 << s_gid);
                hit = -1;
                for (int k = 0; k < sb_q.size(); k++) begin
                    if (hit < 0 && sb_q[k].id == int'(s_gid)) hit = k;
                end
                check_output("sb_has_entry", hit >= 0, 1);
                if (hit >= 0) begin
                    check_output("sb_data", s_wd, sb_q[hit].data);
                    sb_q.delete(hit);
                end
            end
            if (s_gv && !prev_gv) begin
                grant_log.push_back(int'(s_gid));
                burst_words = 0;
            end
            if (s_we) burst_words++;
            if (!s_gv && prev_gv) burst_log.push_back(burst_words);
            prev_gv = s_gv;
        end
    endtask

    task automatic advance();
        logic [7:0] d;
        int id;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s_valid[i] && s_ready[i]) prod_head[i]++;
        end
        if (use_fifo_model) begin
            if (s_we) begin
                check_output("fifo_no_overflow", fifo_q.size() < DEPTH, 1);
                fifo_q.push_back(s_wd);
            end
            if ((cyc % 3 == 0) && (fifo_q.size() > 0)) begin
                d  = fifo_q.pop_front();
                id = int'(d[7:4]);
                check_output("rd_id_valid", id < NUM_REQ, 1);
                if (id < NUM_REQ) begin
                    check_output("rd_order", d[3:0], next_rd_idx[id]);
                    next_rd_idx[id]++;
                end
                rd_count++;
            end
        end
        cyc++;
    endtask

    task automatic step();
        apply_stimulus();
        #4;
        sample_and_score();
        @(posedge write_clk);
        #1;
        advance();
    endtask

    task automatic do_reset();
        write_rst = 1'b1;
        step();
        write_rst = 1'b0;
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        logic [8:0] we_pat;
        logic [8:0] gv_pat;
        int         exp_order [5];
        int         wr;
        int         n;

        total_checks   = 0;
        passed_checks  = 0;
        write_rst      = 1'b1;
        req_valid      = '0;
        req_data       = '0;
        fifo_full      = 1'b0;
        manual_full    = 1'b0;
        use_fifo_model = 1'b0;
        prev_gv        = 1'b0;
        burst_words    = 0;
        rd_count       = 0;
        cyc            = 0;
        clear_all();
        @(posedge write_clk);
        #1;

        $display("[TB] reset and idle");
        do_reset();
        repeat (5) begin
            step();
            check_output("t1_gv", s_gv, 0);
            check_output("t1_we", s_we, 0);
            check_output("t1_ready", s_ready, 0);
        end

        $display("[TB] single requester 2 with six words");
        clear_all();
        for (int k = 0; k < 6; k++) load_word(2, 8'(8'h11 * (k + 1)));
        we_pat = 9'b011011110;
        gv_pat = 9'b111011110;
        wr = 0;
        for (int c = 0; c < 9; c++) begin
            step();
            check_output("t2_we", s_we, we_pat[c]);
            check_output("t2_gv", s_gv, gv_pat[c]);
            if (we_pat[c]) begin
                wr++;
                check_output("t2_data", s_wd, 8'(8'h11 * wr));
                check_output("t2_gid", s_gid, 2);
            end
        end
        step();
        check_output("t2_gv_end", s_gv, 0);
        check_output("t2_sb_empty", sb_q.size(), 0);
        check_output("t2_grants", grant_log.size(), 2);

        $display("[TB] all requesters valid, fairness");
        clear_all();
        do_reset();
        for (int k = 0; k < 8; k++) load_word(0, 8'(k));
        for (int i = 1; i < NUM_REQ; i++) begin
            for (int k = 0; k < 4; k++) load_word(i, 8'((i << 4) | k));
        end
        n = 0;
        while (sb_q.size() > 0 && n < 60) begin
            step();
            n++;
        end
        check_output("t3_done_in_time", sb_q.size(), 0);
        step();
        step();
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
        check_output("t3_grant_count", grant_log.size(), 5);
        check_output("t3_burst_count", burst_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) check_output("t3_grant_order", grant_log[k], exp_order[k]);
            if (k < burst_log.size()) check_output("t3_burst_len", burst_log[k], BURST);
        end

        $display("[TB] stall on fifo_full mid-burst");
        clear_all();
        for (int k = 0; k < 4; k++) load_word(1, 8'(8'hA1 + k));
        step();
        check_output("t4_idle_gv", s_gv, 0);
        step();
        check_output("t4_w1_we", s_we, 1);
        check_output("t4_w1_gid", s_gid, 1);
        step();
        check_output("t4_w2_data", s_wd, 8'hA2);
        manual_full = 1'b1;
        repeat (3) begin
            step();
            check_output("t4_stall_we", s_we, 0);
            check_output("t4_stall_ready", s_ready, 0);
            check_output("t4_stall_gv", s_gv, 1);
            check_output("t4_stall_gid", s_gid, 1);
        end
        manual_full = 1'b0;
        step();
        check_output("t4_w3_data", s_wd, 8'hA3);
        check_output("t4_w3_we", s_we, 1);
        step();
        check_output("t4_w4_data", s_wd, 8'hA4);
        step();
        check_output("t4_release_gv", s_gv, 0);
        check_output("t4_sb_empty", sb_q.size(), 0);

        $display("[TB] reset mid-burst");
        clear_all();
        for (int k = 0; k < 4; k++) load_word(3, 8'(8'hB0 + k));
        step();
        step();
        step();
        check_output("t5_pre_gv", s_gv, 1);
        do_reset();
        step();
        check_output("t5_gv", s_gv, 0);
        check_output("t5_gid", s_gid, 0);
        check_output("t5_we", s_we, 0);
        check_output("t5_ready", s_ready, 0);
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            step();
            n++;
        end
        check_output("t5_remaining_written", sb_q.size(), 0);
        step();
        step();

        $display("[TB] requester 3 drops, wrap to requester 0");
        clear_all();
        do_reset();
        load_word(2, 8'hC0);
        step();
        step();
        check_output("t6_c2_we", s_we, 1);
        check_output("t6_c2_gid", s_gid, 2);
        step();
        check_output("t6_c3_we", s_we, 0);
        load_word(3, 8'hD0);
        load_word(0, 8'hE0);
        load_word(0, 8'hE1);
        step();
        check_output("t6_bubble1_gv", s_gv, 0);
        step();
        check_output("t6_g3_gid", s_gid, 3);
        check_output("t6_g3_data", s_wd, 8'hD0);
        step();
        check_output("t6_drop_gv", s_gv, 1);
        check_output("t6_drop_we", s_we, 0);
        step();
        check_output("t6_bubble2_gv", s_gv, 0);
        step();
        check_output("t6_g0_gv", s_gv, 1);
        check_output("t6_g0_gid", s_gid, 0);
        check_output("t6_g0_data", s_wd, 8'hE0);
        step();
        check_output("t6_g0_data2", s_wd, 8'hE1);
        check_output("t6_sb_empty", sb_q.size(), 0);
        step();
        step();

        $display("[TB] full system with depth-8 FIFO model");
        clear_all();
        do_reset();
        use_fifo_model = 1'b1;
        rd_count = 0;
        cyc = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < 10; k++) load_word(i, 8'((i << 4) | k));
        end
        n = 0;
        while (rd_count < 40 && n < 1500) begin
            step();
            n++;
        end
        check_output("t7_drained", rd_count, 40);
        check_output("t7_sb_empty", sb_q.size(), 0);
        check_output("t7_fifo_empty", fifo_q.size(), 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            check_output("t7_per_req_count", next_rd_idx[i], 10);
        end
        use_fifo_model = 1'b0;

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
